// File: rtl/mdio_arbiter.sv
// mdio_arbiter: round-robin arbiter sharing one MDIO shift engine among NREQ requesters.
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   req[NREQ]             per-requester level request, held until ack
//   cmd[32*NREQ]          per-requester MDIO frame, [29:28]=10 read, 01 write
//   ack[NREQ]             one-cycle completion pulse to the owner
//   err                   with ack: timeout or illegal opcode
//   rdata[16]             read data, held until the next read completes
//   owner[2]              current or last granted requester
//   busy                  high from grant until ack
//   eng_start             start strobe to the shift engine
//   eng_wdata[32]         frame to the engine, stable for the whole transaction
//   eng_rd_done/wr_done   engine level done flags, low while a frame is in flight
//   eng_rdata[16]         engine read result
module mdio_arbiter #(
    parameter int    NREQ           = 3,
    parameter int    TIMEOUT_CYCLES = 65535,
    parameter string HOLD_LAST      = "FALSE"
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   cmd,
    output logic [NREQ-1:0]      ack,
    output logic                 err,
    output logic [15:0]          rdata,
    output logic [1:0]           owner,
    output logic                 busy,
    output logic                 eng_start,
    output logic [31:0]          eng_wdata,
    input  logic                 eng_rd_done,
    input  logic                 eng_wr_done,
    input  logic [15:0]          eng_rdata
);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam bit HOLD = (HOLD_LAST == "TRUE");

    typedef enum logic [2:0] {IDLE, GRANT, STRB, WAIT, RESP} state_t;

    state_t          state_q;
    logic [1:0]      owner_q;
    logic [NREQ-1:0] ack_q;
    logic            err_q;
    logic [15:0]     rdata_q;
    logic            start_q;
    logic [31:0]     wdata_q;
    logic [TW-1:0]   tmo_q;
    logic            hold_q;

    logic [1:0] win_d;
    logic [1:0] idx;
    logic       is_rd;
    logic       is_wr;
    logic       done;
    logic       tmo_hit;

    // Search from owner+1 upward; iterating backwards lets the nearest index win.
    always_comb begin
        win_d = owner_q;
        idx   = owner_q;
        for (int k = NREQ; k >= 1; k--) begin
            idx = 2'((int'(owner_q) + k) % NREQ);
            if (req[idx]) win_d = idx;
        end
        if (HOLD && hold_q && req[owner_q]) win_d = owner_q;
    end

    assign is_rd   = (wdata_q[29:28] == 2'b10);
    assign is_wr   = (wdata_q[29:28] == 2'b01);
    assign done    = is_rd ? eng_rd_done : eng_wr_done;
    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 2'(NREQ - 1);
            ack_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            start_q <= 1'b0;
            wdata_q <= '0;
            tmo_q   <= '0;
            hold_q  <= 1'b0;
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    hold_q <= 1'b0;
                    if (|req) begin
                        owner_q <= win_d;
                        wdata_q <= cmd[{win_d, 5'd0} +: 32];
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    tmo_q <= '0;
                    if (is_rd || is_wr) begin
                        start_q <= 1'b1;
                        state_q <= STRB;
                    end else begin
                        err_q          <= 1'b1;
                        ack_q[owner_q] <= 1'b1;
                        state_q        <= RESP;
                    end
                end
                STRB, WAIT: begin
                    tmo_q <= tmo_q + 1'b1;
                    if (tmo_hit) begin
                        start_q        <= 1'b0;
                        err_q          <= 1'b1;
                        ack_q[owner_q] <= 1'b1;
                        state_q        <= RESP;
                    end else if (state_q == STRB && !done) begin
                        start_q <= 1'b0;
                        state_q <= WAIT;
                    end else if (state_q == WAIT && done) begin
                        if (is_rd) rdata_q <= eng_rdata;
                        err_q          <= 1'b0;
                        ack_q[owner_q] <= 1'b1;
                        state_q        <= RESP;
                    end
                end
                RESP: begin
                    err_q   <= 1'b0;
                    hold_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack       = ack_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign owner     = owner_q;
    assign busy      = (state_q != IDLE);
    assign eng_start = start_q;
    assign eng_wdata = wdata_q;
endmodule

// File: tb/tb_mdio_arbiter.sv
// tb_mdio_arbiter: directed self-checking bench for mdio_arbiter with a small engine model.
module tb_mdio_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = '0;
    logic [95:0] cmd = '0;
    logic [2:0]  ack;
    logic        err;
    logic [15:0] rdata;
    logic [1:0]  owner;
    logic        busy;
    logic        eng_start;
    logic [31:0] eng_wdata;
    logic        rd_done = 1'b1;
    logic        wr_done = 1'b1;
    logic [15:0] eng_rdata_v = '0;

    int passed = 0;
    int total  = 0;
    int starts = 0;
    int acks   = 0;
    int left   = 0;
    bit stuck  = 1'b0;
    logic start_prev = 1'b0;

    mdio_arbiter #(.NREQ(3), .TIMEOUT_CYCLES(16), .HOLD_LAST("FALSE")) dut (
        .clk(clk), .reset(reset), .req(req), .cmd(cmd), .ack(ack), .err(err),
        .rdata(rdata), .owner(owner), .busy(busy), .eng_start(eng_start),
        .eng_wdata(eng_wdata), .eng_rd_done(rd_done), .eng_wr_done(wr_done),
        .eng_rdata(eng_rdata_v)
    );

    always #5 clk = ~clk;

    // Engine model: drops the matching done flag one cycle after start, raises it three cycles later.
    always @(posedge clk) begin
        if (stuck) begin
        end else if (left == 0 && eng_start && rd_done && wr_done) begin
            if (eng_wdata[29:28] == 2'b10) rd_done <= 1'b0;
            else wr_done <= 1'b0;
            left <= 3;
        end else if (left == 1) begin
            rd_done <= 1'b1;
            wr_done <= 1'b1;
            left    <= 0;
        end else if (left > 1) begin
            left <= left - 1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (eng_start && !start_prev) starts++;
        start_prev = eng_start;
        if (ack !== 3'b000) acks++;
    end

    task automatic wait_ack(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (ack !== 3'b000) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_wait_state(output bit ok);
        bit hi = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (eng_start) hi = 1'b1;
            else if (hi) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (ack !== 3'b000) $display("FAIL reset_ack got %b want 000", ack); else passed++;
        total++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else passed++;
        total++; if (rdata !== 16'h0000) $display("FAIL reset_rdata got %h want 0000", rdata); else passed++;
        total++; if (owner !== 2'd2) $display("FAIL reset_owner got %0d want 2", owner); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (eng_start !== 1'b0) $display("FAIL reset_start got %b want 0", eng_start); else passed++;
        total++; if (eng_wdata !== 32'h0) $display("FAIL reset_wdata got %h want 0", eng_wdata); else passed++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read;
        int cyc;
        int s0;
        cmd[31:0]   = 32'h6046_0000;
        eng_rdata_v = 16'hAC00;
        s0  = starts;
        req = 3'b001;
        wait_ack(cyc);
        total++; if (cyc != 7) $display("FAIL read_latency got %0d want 7", cyc); else passed++;
        total++; if (ack !== 3'b001) $display("FAIL read_ack got %b want 001", ack); else passed++;
        total++; if (err !== 1'b0) $display("FAIL read_err got %b want 0", err); else passed++;
        total++; if (rdata !== 16'hAC00) $display("FAIL read_rdata got %h want ac00", rdata); else passed++;
        total++; if (owner !== 2'd0) $display("FAIL read_owner got %0d want 0", owner); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL read_busy_resp got %b want 1", busy); else passed++;
        req = 3'b000;
        @(negedge clk);
        total++; if (ack !== 3'b000) $display("FAIL read_ack_pulse got %b want 000", ack); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL read_busy_idle got %b want 0", busy); else passed++;
        total++; if (starts - s0 != 1) $display("FAIL read_start_count got %0d want 1", starts - s0); else passed++;
    endtask

    task automatic test_round_robin;
        logic [2:0]  exp_a[4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        logic [1:0]  exp_o[4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        logic [31:0] exp_w[4] = '{32'h5002_0001, 32'h5002_0002, 32'h5002_0003, 32'h5002_0001};
        int cyc;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cmd = {32'h5002_0003, 32'h5002_0002, 32'h5002_0001};
        req = 3'b111;
        for (int n = 0; n < 4; n++) begin
            wait_ack(cyc);
            total++; if (ack !== exp_a[n]) $display("FAIL rr_ack%0d got %b want %b", n, ack, exp_a[n]); else passed++;
            total++; if (owner !== exp_o[n]) $display("FAIL rr_owner%0d got %0d want %0d", n, owner, exp_o[n]); else passed++;
            total++; if (eng_wdata !== exp_w[n]) $display("FAIL rr_wdata%0d got %h want %h", n, eng_wdata, exp_w[n]); else passed++;
            @(negedge clk);
            total++; if (ack !== 3'b000) $display("FAIL rr_gap%0d got %b want 000", n, ack); else passed++;
        end
        req = 3'b000;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    endtask

    task automatic test_illegal;
        int cyc;
        int s0;
        cmd[31:0] = 32'h7000_0000;
        s0  = starts;
        req = 3'b001;
        wait_ack(cyc);
        total++; if (cyc != 2) $display("FAIL illegal_latency got %0d want 2", cyc); else passed++;
        total++; if (ack !== 3'b001) $display("FAIL illegal_ack got %b want 001", ack); else passed++;
        total++; if (err !== 1'b1) $display("FAIL illegal_err got %b want 1", err); else passed++;
        total++; if (starts != s0) $display("FAIL illegal_start got %0d want %0d", starts, s0); else passed++;
        total++; if (rdata !== 16'h0000) $display("FAIL illegal_rdata got %h want 0000", rdata); else passed++;
        req = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int cyc;
        bit found = 1'b0;
        stuck       = 1'b1;
        cmd[31:0]   = 32'h5002_00FF;
        eng_rdata_v = 16'h1234;
        req = 3'b001;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (eng_start) begin
                found = 1'b1;
                break;
            end
        end
        total++; if (!found) $display("FAIL tmo_start got 0 want 1"); else passed++;
        wait_ack(cyc);
        total++; if (cyc != 17) $display("FAIL tmo_latency got %0d want 17", cyc); else passed++;
        total++; if (err !== 1'b1) $display("FAIL tmo_err got %b want 1", err); else passed++;
        total++; if (eng_start !== 1'b0) $display("FAIL tmo_start_off got %b want 0", eng_start); else passed++;
        total++; if (rdata !== 16'h0000) $display("FAIL tmo_rdata got %h want 0000", rdata); else passed++;
        req = 3'b000;
        @(negedge clk);
        total++; if (eng_start !== 1'b0) $display("FAIL tmo_start_after got %b want 0", eng_start); else passed++;
        stuck = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_wait;
        bit ok;
        int a0;
        int cyc;
        cmd[63:32] = 32'h5002_0011;
        req = 3'b010;
        wait_wait_state(ok);
        total++; if (!ok) $display("FAIL rstw_reach_wait got 0 want 1"); else passed++;
        a0 = acks;
        reset = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL rstw_busy got %b want 0", busy); else passed++;
        total++; if (owner !== 2'd2) $display("FAIL rstw_owner got %0d want 2", owner); else passed++;
        total++; if (eng_wdata !== 32'h0) $display("FAIL rstw_wdata got %h want 0", eng_wdata); else passed++;
        total++; if (eng_start !== 1'b0) $display("FAIL rstw_start got %b want 0", eng_start); else passed++;
        total++; if (ack !== 3'b000 || err !== 1'b0) $display("FAIL rstw_ack_err got %b/%b want 000/0", ack, err); else passed++;
        for (int i = 0; i < 4; i++) @(negedge clk);
        total++; if (acks != a0) $display("FAIL rstw_no_ack got %0d want %0d", acks, a0); else passed++;
        reset = 1'b0;
        @(negedge clk);
        total++; if (owner !== 2'd1 || busy !== 1'b1) $display("FAIL rstw_regrant got owner %0d busy %b want 1/1", owner, busy); else passed++;
        wait_ack(cyc);
        total++; if (ack !== 3'b010) $display("FAIL rstw_ack got %b want 010", ack); else passed++;
        req = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_drop;
        bit ok;
        int a0;
        int cyc;
        cmd[63:32] = 32'h5002_0022;
        req = 3'b010;
        a0 = acks;
        wait_wait_state(ok);
        total++; if (!ok) $display("FAIL drop_reach_wait got 0 want 1"); else passed++;
        req = 3'b000;
        cmd[63:32] = 32'h5002_0033;
        @(negedge clk);
        total++; if (eng_wdata !== 32'h5002_0022) $display("FAIL drop_wdata got %h want 50020022", eng_wdata); else passed++;
        wait_ack(cyc);
        total++; if (ack !== 3'b010) $display("FAIL drop_ack got %b want 010", ack); else passed++;
        for (int i = 0; i < 6; i++) @(negedge clk);
        total++; if (acks - a0 != 1) $display("FAIL drop_ack_count got %0d want 1", acks - a0); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL drop_busy got %b want 0", busy); else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_read;
        test_round_robin;
        test_illegal;
        test_timeout;
        test_reset_wait;
        test_drop;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mdio_arbiter.md
MDIO_ARBITER -- requirements
Module: mdio_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3: number of requesters (2..4).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535: engine-phase cycle limit before abort.
REQ-003 SHALL have parameter HOLD_LAST, default "FALSE": when "TRUE", the last winner keeps priority if it re-requests in the cycle after ack.
REQ-004 clk  in  1  system clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req  in  NREQ  per-requester transaction request; level, held until ack.
REQ-007 cmd  in  32*NREQ  per-requester MDIO frame; slice i = bits [32i+31:32i]; [29:28]=10 read, 01 write.
REQ-008 ack  out  NREQ  one-cycle completion pulse to the owning requester.
REQ-009 err  out  1  valid with ack; 1 = timeout or illegal opcode.
REQ-010 rdata  out  16  read data, valid with ack; held until the next ack.
REQ-011 owner  out  2  index of the current or last grant.
REQ-012 busy  out  1  high from grant until ack, inclusive.
REQ-013 eng_start  out  1  start strobe to the shared shift_mdio engine.
REQ-014 eng_wdata  out  32  frame to the engine; stable from grant until ack.
REQ-015 eng_rd_done / eng_wr_done  in  1 each  engine level done flags; low while a frame is in flight.
REQ-016 eng_rdata  in  16  engine read result.

Function
REQ-017 SHALL implement states IDLE, GRANT, STRB, WAIT, RESP.
REQ-018 IDLE: if any req is set, SHALL pick a winner round-robin, starting the search at the index after the last winner, and go to GRANT; otherwise stay in IDLE.
REQ-019 GRANT: SHALL latch cmd of the winner into eng_wdata and set owner; an opcode other than 10 or 01 SHALL go directly to RESP with err=1, without issuing eng_start.
REQ-020 STRB: SHALL assert eng_start; the done flag matching the opcode (rd for 10, wr for 01) going low SHALL move the FSM to WAIT.
REQ-021 WAIT: SHALL deassert eng_start; the matching done flag going high SHALL move the FSM to RESP.
REQ-022 RESP: SHALL pulse ack[owner] for exactly 1 cycle; for reads, SHALL load rdata from eng_rdata and set err=0; SHALL then return to IDLE.
REQ-023 Minimum latency from req to ack SHALL be GRANT + STRB + engine time + RESP; there SHALL be no back-to-back grants without passing through IDLE.
REQ-024 A timeout counter SHALL clear on GRANT and count in STRB and WAIT; reaching TIMEOUT_CYCLES SHALL force RESP with err=1 and deassert eng_start; rdata SHALL remain unchanged.
REQ-025 Deasserting req mid-transaction SHALL NOT abort; the frame SHALL complete and ack SHALL still pulse.
REQ-026 Simultaneous requests SHALL be served in rotating order; no requester SHALL wait more than NREQ-1 transactions while continuously requesting.
REQ-027 A requester re-asserting req in its own ack cycle SHALL be treated as a new request; under HOLD_LAST="FALSE" it SHALL get the lowest priority.
REQ-028 cmd changes after GRANT SHALL be ignored until the next grant.
REQ-029 busy SHALL be 1 in GRANT, STRB, WAIT and RESP, and 0 in IDLE.

Reset
REQ-030 reset SHALL force IDLE, ack=0, err=0, rdata=0, owner=NREQ-1 (so requester 0 is searched first), busy=0, eng_start=0, eng_wdata=0, timeout counter=0.
REQ-031 reset asserted mid-transaction SHALL take effect immediately; no ack SHALL be issued for the interrupted frame.

Verification
REQ-032 req=001, cmd0=0x6?? read reg 17, engine model returns 0xAC00 -> one eng_start episode, ack=001 for 1 cycle, rdata=0xAC00, err=0.
REQ-033 req=111 held, all writes -> acks in order 001, 010, 100, 001; no two acks adjacent.
REQ-034 Engine done never returns low, TIMEOUT_CYCLES=16 -> ack with err=1 exactly 17 cycles after STRB entry (16 counted cycles, then 1 cycle into RESP); eng_start=0 afterward.
REQ-035 cmd[29:28]=11 -> ack with err=1 two cycles after req; eng_start never asserts.
REQ-036 Reset asserted in WAIT -> all outputs at reset values the next cycle; a subsequent req=010 is granted owner=1.
REQ-037 req1 drops during WAIT -> transaction completes and ack=010 still pulses once.
